// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL reset sequencing, lock qualification and downstream reset release
module pll_lock_ctrl #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 7
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               pll_locked,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [7:0]                         lock_loss_cnt
);

    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RET_W     = $clog2(MAX_RETRIES+1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RET_W-1:0] ret_t;

    localparam cnt_t RST_LAST     = cnt_t'(RST_PULSE_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
    localparam ret_t RET_MAX      = ret_t'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t     state, state_n;
    cnt_t       cnt, cnt_n;
    ret_t       retry_n;
    logic [7:0] llc_n;
    logic       sync_ff, locked_s;

    // pll_locked is asynchronous to refclk; only locked_s is ever used
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_ff  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_ff  <= pll_locked;
            locked_s <= sync_ff;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry_cnt;
        llc_n   = lock_loss_cnt;
        unique case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + cnt_t'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_n = '0;
                    if (retry_cnt == RET_MAX) begin
                        state_n = FAULT;
                    end else begin
                        retry_n = retry_cnt + ret_t'(1);
                        state_n = RESET_PLL;
                    end
                end else begin
                    cnt_n = cnt + cnt_t'(1);
                end
            end
            STABLE: begin
                // a glitch restarts qualification with a fresh timeout, no retry spent
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + cnt_t'(1);
                end
            end
            RUN: begin
                if (!locked_s || relock_req) begin
                    if (!locked_s && lock_loss_cnt != 8'hff) begin
                        llc_n = lock_loss_cnt + 8'd1;
                    end
                    retry_n = '0;
                    cnt_n   = '0;
                    state_n = RESET_PLL;
                end
            end
            FAULT: begin
                if (relock_req) begin
                    retry_n = '0;
                    cnt_n   = '0;
                    state_n = RESET_PLL;
                end
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase
    end

    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            retry_cnt     <= retry_n;
            lock_loss_cnt <= llc_n;
            pll_rst       <= (state_n == RESET_PLL) || (state_n == FAULT);
            sys_rst       <= (state_n != RUN);
            ready         <= (state_n == RUN);
            fail          <= (state_n == FAULT);
        end
    end

endmodule
